// File: rtl/bcd_updown_cnt.sv
// Multi-decade synchronous BCD up/down counter with parallel load, wrap or saturate
// at terminal count, cascade enable and a registered terminal-event pulse.
module bcd_updown_cnt #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic                  CE,
  input  logic                  CI,
  input  logic                  Up_Down,
  input  logic [4*DIGITS-1:0]   P,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  MAX_MIN,
  output logic                  RC,
  output logic                  TC_PULSE
);

  logic                en;
  logic                at_term;
  logic [4*DIGITS-1:0] q_q, q_d;
  logic [4*DIGITS-1:0] q_step;
  logic [4*DIGITS-1:0] p_clamp;
  logic                tc_q, tc_d;
  logic                held_q, held_d;

  // chain[k] is set when every decade below k sits at the terminal digit for the
  // current direction, i.e. decade k is the one that steps this cycle.
  logic [DIGITS:0]     chain;

  assign en       = ~CE & CI;
  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    logic [3:0] d;
    logic [3:0] p_nib;
    logic [3:0] nxt;

    assign d            = q_q[4*k +: 4];
    assign p_nib        = P[4*k +: 4];
    assign chain[k+1]   = chain[k] & (Up_Down ? (d == 4'd0) : (d == 4'd9));
    assign p_clamp[4*k +: 4] = (p_nib > 4'd9) ? 4'd9 : p_nib;

    always_comb begin
      nxt = d;
      if (chain[k]) begin
        if (Up_Down) begin
          nxt = (d == 4'd0) ? 4'd9 : d - 4'd1;
        end else begin
          nxt = (d == 4'd9) ? 4'd0 : d + 4'd1;
        end
      end
    end

    assign q_step[4*k +: 4] = nxt;
  end

  assign at_term = chain[DIGITS];

  // held_q remembers that the saturating counter already reported reaching terminal.
  always_comb begin
    q_d    = q_q;
    tc_d   = 1'b0;
    held_d = held_q;
    if (!LOAD) begin
      q_d    = p_clamp;
      held_d = 1'b0;
    end else if (en) begin
      if (at_term && !WRAP) begin
        tc_d   = ~held_q;
        held_d = 1'b1;
      end else begin
        q_d    = q_step;
        tc_d   = at_term;
        held_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      tc_q   <= 1'b0;
      held_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      tc_q   <= tc_d;
      held_q <= held_d;
    end
  end

  assign Q        = q_q;
  assign TC_PULSE = tc_q;
  assign MAX_MIN  = at_term;
  assign RC       = ~(at_term & en);

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Bench for bcd_updown_cnt: integer-valued reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_updown_cnt;

  logic        CLK, RST, LOAD, CE, Up_Down;
  logic [7:0]  pa, pc;
  logic [11:0] pb;
  logic [7:0]  qa;
  logic [11:0] qb;
  logic [3:0]  qlo, qhi;
  logic        mma, rca, tca, mmb, rcb, tcb;
  logic        mmlo, rclo, tclo, mmhi, rchi, tchi;

  int checks = 0;
  int errors = 0;

  // A: 2 decades wrapping; B: 3 decades saturating; lo/hi: cascaded single decades
  bcd_updown_cnt #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .CE(CE), .CI(1'b1), .Up_Down(Up_Down),
    .P(pa), .Q(qa), .MAX_MIN(mma), .RC(rca), .TC_PULSE(tca));
  bcd_updown_cnt #(.DIGITS(3), .WRAP(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .CE(CE), .CI(1'b1), .Up_Down(Up_Down),
    .P(pb), .Q(qb), .MAX_MIN(mmb), .RC(rcb), .TC_PULSE(tcb));
  bcd_updown_cnt #(.DIGITS(1), .WRAP(1'b1)) u_lo (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .CE(CE), .CI(1'b1), .Up_Down(Up_Down),
    .P(pc[3:0]), .Q(qlo), .MAX_MIN(mmlo), .RC(rclo), .TC_PULSE(tclo));
  bcd_updown_cnt #(.DIGITS(1), .WRAP(1'b1)) u_hi (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .CE(CE), .CI(~rclo), .Up_Down(Up_Down),
    .P(pc[7:4]), .Q(qhi), .MAX_MIN(mmhi), .RC(rchi), .TC_PULSE(tchi));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp_val(input logic [31:0] p, input int d);
    int v = 0;
    int w = 1;
    for (int k = 0; k < d; k++) begin
      logic [3:0] nib;
      nib = p[4*k +: 4];
      v += ((nib > 4'd9) ? 9 : int'(nib)) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int x = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Counter as an integer in 0..maxv; held marks "already reported saturation".
  task automatic mstep(input int v, input int maxv, input bit wrap, input bit held,
                       input bit ld, input int pv, input bit en, input bit dn,
                       output int nv, output bit ntc, output bit nheld);
    nv = v; ntc = 1'b0; nheld = held;
    if (ld) begin
      nv = pv; nheld = 1'b0;
    end else if (en) begin
      if ((!dn && v == maxv) || (dn && v == 0)) begin
        if (wrap) begin
          nv = dn ? maxv : 0; ntc = 1'b1;
        end else begin
          ntc = !held; nheld = 1'b1;
        end
      end else begin
        nv = dn ? v - 1 : v + 1; nheld = 1'b0;
      end
    end
  endtask

  int va = 0, vb = 0, vc = 0;
  bit ta = 0, tb = 0, tlo = 0, thi = 0, hb = 0;
  int nva, nvb, nvc;
  bit nta, ntb, ntc_c, nhb, dmy;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      va = 0; vb = 0; vc = 0; ta = 0; tb = 0; tlo = 0; thi = 0; hb = 0;
    end else begin
      mstep(va, 99, 1'b1, 1'b0, !LOAD, clamp_val(32'(pa), 2), !CE, Up_Down, nva, nta, dmy);
      mstep(vb, 999, 1'b0, hb, !LOAD, clamp_val(32'(pb), 3), !CE, Up_Down, nvb, ntb, nhb);
      mstep(vc, 99, 1'b1, 1'b0, !LOAD, clamp_val(32'(pc), 2), !CE, Up_Down, nvc, ntc_c, dmy);
      tlo = LOAD && !CE && (Up_Down ? (vc % 10 == 0) : (vc % 10 == 9));
      thi = ntc_c;
      va = nva; ta = nta; vb = nvb; tb = ntb; hb = nhb; vc = nvc;
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    bit en, ma, mb, ml, mh;
    en = !CE;
    ma = Up_Down ? (va == 0) : (va == 99);
    mb = Up_Down ? (vb == 0) : (vb == 999);
    ml = Up_Down ? (vc % 10 == 0) : (vc % 10 == 9);
    mh = Up_Down ? (vc / 10 == 0) : (vc / 10 == 9);
    chk("qa", 32'(qa), to_bcd(va, 2));
    chk("tca", 32'(tca), 32'(ta));
    chk("mma", 32'(mma), 32'(ma));
    chk("rca", 32'(rca), 32'(!(ma && en)));
    chk("qb", 32'(qb), to_bcd(vb, 3));
    chk("tcb", 32'(tcb), 32'(tb));
    chk("mmb", 32'(mmb), 32'(mb));
    chk("rcb", 32'(rcb), 32'(!(mb && en)));
    chk("qcasc", 32'({qhi, qlo}), to_bcd(vc, 2));
    chk("tclo", 32'(tclo), 32'(tlo));
    chk("tchi", 32'(tchi), 32'(thi));
    chk("mmlo", 32'(mmlo), 32'(ml));
    chk("mmhi", 32'(mmhi), 32'(mh));
    chk("rclo", 32'(rclo), 32'(!(ml && en)));
    chk("rchi", 32'(rchi), 32'(!(mh && ml && en)));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  int pulses;
  logic [7:0] down_exp [3];

  initial begin
    down_exp[0] = 8'h38; down_exp[1] = 8'h37; down_exp[2] = 8'h36;
    RST = 1'b1; LOAD = 1'b1; CE = 1'b1; Up_Down = 1'b0;
    pa = '0; pb = '0; pc = '0;
    tick(2);
    RST = 1'b0;
    chk("rst_q", 32'(qa), 32'h0);
    chk("rst_tc", 32'(tca), 32'h0);
    chk("rst_mm_up", 32'(mma), 32'h0);
    chk("rst_rc_up", 32'(rca), 32'h1);
    Up_Down = 1'b1; CE = 1'b0;
    #1;
    chk("rst_mm_dn", 32'(mma), 32'h1);
    chk("rst_rc_dn", 32'(rca), 32'h0);
    Up_Down = 1'b0; CE = 1'b1;

    // Full up sweep to terminal and wrap
    tick(1);
    CE = 1'b0;
    tick(99);
    chk("up99_q", 32'(qa), 32'h99);
    chk("up99_mm", 32'(mma), 32'h1);
    chk("up99_rc", 32'(rca), 32'h0);
    tick(1);
    chk("wrap_q", 32'(qa), 32'h00);
    chk("wrap_tc", 32'(tca), 32'h1);
    // Asynchronous reset in the middle of the pulse cycle
    #1 RST = 1'b1;
    #1;
    chk("arst_q", 32'(qa), 32'h0);
    chk("arst_tc", 32'(tca), 32'h0);
    chk("arst_qb", 32'(qb), 32'h0);
    #2 RST = 1'b0;
    tick(3);
    chk("resume_q", 32'(qa), 32'h03);

    // Reset at Q=57
    LOAD = 1'b0; pa = 8'h56;
    tick(1);
    LOAD = 1'b1;
    tick(1);
    chk("q57", 32'(qa), 32'h57);
    #1 RST = 1'b1;
    #1;
    chk("arst57_q", 32'(qa), 32'h0);
    #2 RST = 1'b0;
    tick(1);

    // Load with clamping, then count down
    CE = 1'b1; LOAD = 1'b0; pa = 8'h3F; pb = 12'hA5F; pc = 8'h3F;
    tick(1);
    LOAD = 1'b1;
    chk("ld_qa", 32'(qa), 32'h39);
    chk("ld_qb", 32'(qb), 32'h959);
    chk("ld_casc", 32'({qhi, qlo}), 32'h39);
    CE = 1'b0; Up_Down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("down_q", 32'(qa), 32'(down_exp[i]));
    end

    // Saturating counter held at zero
    CE = 1'b1; LOAD = 1'b0; pb = 12'h001;
    tick(1);
    LOAD = 1'b1; CE = 1'b0;
    pulses = 0;
    repeat (5) begin
      tick(1);
      pulses += int'(tcb);
      chk("sat0_mm", 32'(mmb), 32'h1);
    end
    chk("sat0_q", 32'(qb), 32'h000);
    chk("sat0_pulses", 32'(pulses), 32'h1);

    // Saturating counter held at 999
    CE = 1'b1; LOAD = 1'b0; pb = 12'h998; Up_Down = 1'b0;
    tick(1);
    LOAD = 1'b1; CE = 1'b0;
    pulses = 0;
    repeat (4) begin
      tick(1);
      pulses += int'(tcb);
    end
    chk("sat9_q", 32'(qb), 32'h999);
    chk("sat9_pulses", 32'(pulses), 32'h1);

    // Load wins over count
    CE = 1'b1; LOAD = 1'b0; pa = 8'h45;
    tick(1);
    chk("pre_ld", 32'(qa), 32'h45);
    CE = 1'b0; Up_Down = 1'b0; pa = 8'h12;
    tick(1);
    chk("ld_wins", 32'(qa), 32'h12);
    LOAD = 1'b1; CE = 1'b1;

    // Cascaded pair
    #1 RST = 1'b1;
    #2 RST = 1'b0;
    tick(1);
    CE = 1'b0; Up_Down = 1'b0;
    tick(25);
    chk("casc25", 32'({qhi, qlo}), 32'h25);
    Up_Down = 1'b1;
    tick(6);
    chk("casc19", 32'({qhi, qlo}), 32'h19);
    CE = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
